shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Parametrised universal shift register with a built-in multi-step shift sequencer. Single-cycle operations (load, logical/arithmetic shift, rotate, clear) execute under an enable; a start command runs an N-step shift autonomously with a busy/done handshake. It is the general-purpose storage and shift element for the datapath and FSM labs, replacing the single-bit D flip-flop with synchronous clear.

## Interface

- WIDTH, 8, register width in bits (≥2).
- AMT_W, 4, width of the shift-amount input; 2^AMT_W − 1 ≥ WIDTH.

- clk  in  1  rising-edge clock; sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- clear_n  in  1  synchronous clear, active low.
- en  in  1  execute single-cycle `mode` operation this edge.
- start  in  1  begin a multi-step shift of `amt` steps using `mode`.
- mode  in  3  000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 asr, 111 zero.
- d  in  WIDTH  parallel load data.
- ser_in  in  1  serial fill bit for shl (into LSB) and shr (into MSB).
- amt  in  AMT_W  step count for `start`.
- q  out  WIDTH  register contents.
- msb_out  out  1  q[WIDTH-1], combinational from register.
- lsb_out  out  1  q[0], combinational from register.
- busy  out  1  multi-step sequence in progress.
- done  out  1  one-cycle pulse on sequence completion.

## Operation

- Reset (reset_n=0, asynchronous): q=0, busy=0, done=0, step counter=0, state IDLE.
- States: IDLE, RUN.
- Per-edge priority: clear_n=0 > RUN step > start > en.
- clear_n=0: q←0, state←IDLE, busy←0, done←0 (an aborted sequence never pulses done).
- IDLE, en=1, start=0: apply `mode` once. shl: {q[W-2:0],ser_in}; shr: {ser_in,q[W-1:1]}; rotl/rotr: circular; asr: {q[W-1],q[W-1:1]}; load: d; zero: 0; hold: q.
- IDLE, start=1, mode in 010–110, amt≠0: latch mode, counter←amt, state←RUN; q unchanged at this edge. en ignored.
- IDLE, start=1, amt=0 (shift mode): q unchanged, done=1 next cycle, stays IDLE.
- IDLE, start=1, mode in {000,001,111}: start ignored; en handled normally.
- RUN: each edge applies the latched mode once, counter decrements; on the edge where counter reaches 0: state←IDLE, done←1. ser_in sampled live on every step.
- start, en, mode, amt ignored while in RUN.
- amt > WIDTH is legal: all steps performed (logical shifts saturate at all-fill, rotates wrap).
- done is high exactly one cycle; a new start is accepted in the cycle done is high.

## Timing

- Single-cycle op: q reflects result immediately after the sampling edge.
- Start sampled at edge k (amt=N≥1): busy=1 after edge k; steps at edges k+1…k+N; after edge k+N busy=0, done=1; done=0 after edge k+N+1. Total latency N+1 cycles.
- amt=0: done=1 after edge k, busy never asserted.
- reset_n assertion takes effect immediately, mid-sequence included; deassertion is synchronised by the integrator and not by this block.
- msb_out/lsb_out have no added register latency relative to q.

## Test plan

- Reset: drive reset_n=0 asynchronously mid-cycle with q=0xFF, busy=1 -> q=0x00, busy=0, done=0 before next edge.
- Load 0xA5 (en, mode=001), then start rotl amt=3 -> busy for 3 cycles, q=0x2D, done single pulse at cycle 4.
- Load 0x90, start asr amt=2 -> q=0xE4; load 0x01, start shl amt=4 with ser_in=1 -> q=0x1F.
- Start shr amt=6 on 0xFF, drop clear_n in step 3 -> q=0x00, busy=0 next cycle, no done pulse.
- start with amt=0 (mode=010) on q=0x3C -> q stays 0x3C, done=1 one cycle, busy never high; start with mode=001 -> ignored.
- During RUN, toggle en with mode=001, d=0x55, and re-assert start -> ignored, sequence completes with expected value; back-to-back start in the done cycle accepted.

Source files
------------

// File: rtl/shift_sequencer.sv
// Universal shift register with an autonomous N-step shift sequencer.
// Single-cycle ops run under en; start runs amt steps of a shift mode with busy/done.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_n,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             msb_out,
    output logic             lsb_out,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | single-cycle ops under en, start accepted for shift modes
    // RUN   | one latched-mode step per edge until the step counter empties
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROTL = 3'b100;
    localparam logic [2:0] OP_ROTR = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             ser,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            OP_HOLD: res = cur;
            OP_LOAD: res = din;
            OP_SHL:  res = {cur[WIDTH-2:0], ser};
            OP_SHR:  res = {ser, cur[WIDTH-1:1]};
            OP_ROTL: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ROTR: res = {cur[0], cur[WIDTH-1:1]};
            OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_ZERO: res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // hold, load and zero are not sequenceable; start is ignored for them
    function automatic logic is_shift(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= OP_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (!clear_n) begin
            state_d = ST_IDLE;
            q_d     = '0;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            q_d   = apply_op(mode_q, q_q, ser_in, d);
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start && is_shift(mode)) begin
            if (amt == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                mode_d  = mode;
                cnt_d   = amt;
            end
        end else if (en) begin
            q_d = apply_op(mode, q_q, ser_in, d);
        end
    end

    always_comb begin
        q       = q_q;
        msb_out = q_q[WIDTH-1];
        lsb_out = q_q[0];
        busy    = (state_q == ST_RUN);
        done    = done_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: sequence results are scoreboarded and
// checked by a monitor on each done pulse; single-cycle behaviour is checked inline.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    typedef struct {
        logic [7:0] q;
        int         steps;
        string      name;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear_n;
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             ser_in;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] q;
    logic             msb_out;
    logic             lsb_out;
    logic             busy;
    logic             done;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   bcnt  = 0;
    logic prev_done = 1'b0;

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .reset_n(reset_n), .clear_n(clear_n), .en(en), .start(start),
        .mode(mode), .d(d), .ser_in(ser_in), .amt(amt), .q(q),
        .msb_out(msb_out), .lsb_out(lsb_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] dd, input logic s);
        en = 1'b1; mode = m; d = dd; ser_in = s;
        step();
        en = 1'b0; mode = 3'b000;
    endtask

    task automatic seq(input logic [2:0] m, input logic [3:0] a, input logic s,
                       input logic push, input logic [7:0] expq, input string nm);
        exp_t e;
        if (push) begin
            e.q = expq; e.steps = int'(a); e.name = nm;
            sb.push_back(e);
        end
        start = 1'b1; mode = m; amt = a; ser_in = s; en = 1'b0;
        step();
        start = 1'b0; mode = 3'b000; amt = '0;
    endtask

    // monitor: every done pulse must match the oldest outstanding sequence
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (prev_done) chk("done_width", 8'(prev_done && done), 8'h00);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 8'(done), 8'h00);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_q"}, q, e.q);
                    chk({e.name, "_busy_cycles"}, 8'(bcnt), 8'(e.steps));
                    chk({e.name, "_busy_at_done"}, 8'(busy), 8'h00);
                end
                bcnt = 0;
            end else if (busy) begin
                bcnt++;
            end else begin
                bcnt = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        reset_n = 1'b0; clear_n = 1'b1; en = 1'b0; start = 1'b0;
        mode = 3'b000; d = '0; ser_in = 1'b0; amt = '0;
        #12;
        chk("reset_q", q, 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);
        chk("reset_done", 8'(done), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // single-cycle ops
        op(3'b001, 8'h96, 1'b0); chk("load", q, 8'h96);
        chk("msb_96", 8'(msb_out), 8'h01);
        chk("lsb_96", 8'(lsb_out), 8'h00);
        op(3'b010, 8'h00, 1'b1); chk("shl_ser1", q, 8'h2D);
        chk("msb_2d", 8'(msb_out), 8'h00);
        chk("lsb_2d", 8'(lsb_out), 8'h01);
        op(3'b011, 8'h00, 1'b1); chk("shr_ser1", q, 8'h96);
        op(3'b101, 8'h00, 1'b0); chk("rotr", q, 8'h4B);
        op(3'b110, 8'h00, 1'b1); chk("asr_pos", q, 8'h25);
        op(3'b100, 8'h00, 1'b0); chk("rotl", q, 8'h4A);
        op(3'b000, 8'hFF, 1'b1); chk("hold", q, 8'h4A);
        op(3'b111, 8'hFF, 1'b1); chk("zero", q, 8'h00);
        op(3'b001, 8'h7E, 1'b0);
        clear_n = 1'b0;
        op(3'b001, 8'hFF, 1'b0); chk("clear_beats_load", q, 8'h00);
        clear_n = 1'b1;

        // multi-step sequences
        op(3'b001, 8'hA5, 1'b0);
        seq(3'b100, 4'd3, 1'b0, 1'b1, 8'h2D, "rotl3");
        chk("rotl3_busy", 8'(busy), 8'h01);
        chk("rotl3_q_start", q, 8'hA5);
        repeat (4) step();

        op(3'b001, 8'h90, 1'b0);
        seq(3'b110, 4'd2, 1'b0, 1'b1, 8'hE4, "asr2");
        repeat (3) step();

        op(3'b001, 8'h01, 1'b0);
        seq(3'b010, 4'd4, 1'b1, 1'b1, 8'h1F, "shl4");
        repeat (5) step();

        op(3'b001, 8'hA5, 1'b0);
        seq(3'b100, 4'd9, 1'b0, 1'b1, 8'h4B, "rotl9");
        repeat (10) step();

        // clear mid-sequence: no done may follow
        op(3'b001, 8'hFF, 1'b0);
        seq(3'b011, 4'd6, 1'b0, 1'b0, 8'h00, "shr6");
        step(); step();
        clear_n = 1'b0;
        step();
        chk("abort_q", q, 8'h00);
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_done", 8'(done), 8'h00);
        clear_n = 1'b1;
        repeat (8) step();
        chk("abort_no_done", 8'(done), 8'h00);

        // amt = 0 and non-shift start
        op(3'b001, 8'h3C, 1'b0);
        seq(3'b010, 4'd0, 1'b0, 1'b1, 8'h3C, "amt0");
        chk("amt0_done_now", 8'(done), 8'h01);
        chk("amt0_busy", 8'(busy), 8'h00);
        step();
        chk("amt0_done_drop", 8'(done), 8'h00);
        en = 1'b1; start = 1'b1; mode = 3'b001; d = 8'h5A; amt = 4'd3;
        step();
        en = 1'b0; start = 1'b0; mode = 3'b000;
        chk("start_load_q", q, 8'h5A);
        chk("start_load_busy", 8'(busy), 8'h00);
        step();
        chk("start_load_nodone", 8'(done), 8'h00);

        // inputs ignored in RUN, then back-to-back start in the done cycle
        op(3'b001, 8'h81, 1'b0);
        seq(3'b101, 4'd5, 1'b0, 1'b1, 8'h0C, "rotr5");
        en = 1'b1; start = 1'b1; mode = 3'b001; d = 8'h55; amt = 4'd2;
        repeat (5) step();
        chk("rotr5_done_now", 8'(done), 8'h01);
        seq(3'b010, 4'd2, 1'b0, 1'b1, 8'h30, "b2b_shl2");
        chk("b2b_busy", 8'(busy), 8'h01);
        repeat (4) step();

        // asynchronous reset mid-cycle during a sequence
        op(3'b001, 8'hFF, 1'b0);
        seq(3'b011, 4'd6, 1'b0, 1'b0, 8'h00, "shr6r");
        chk("pre_reset_busy", 8'(busy), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_q", q, 8'h00);
        chk("async_reset_busy", 8'(busy), 8'h00);
        chk("async_reset_done", 8'(done), 8'h00);
        reset_n = 1'b1;
        repeat (8) step();
        chk("post_reset_done", 8'(done), 8'h00);

        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            step();
        end
        if (sb.size() != 0) chk("scoreboard_drain", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
